// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with init sweep (optional forwarding: REGFILE_BYPASS_EN)
module regfile_mp #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int NREAD     = 2,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic                     r_clr,
  output logic                     r_busy,
  input  logic                     r_wr_en0,
  input  logic [AWIDTH-1:0]        r_addr_in0,
  input  logic [DWIDTH-1:0]        r_data_in0,
  input  logic                     r_wr_en1,
  input  logic [AWIDTH-1:0]        r_addr_in1,
  input  logic [DWIDTH-1:0]        r_data_in1,
  output logic                     r_wr_drop,
  input  logic [NREAD*AWIDTH-1:0]  r_addr_out,
  output logic [NREAD*DWIDTH-1:0]  r_data_out
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_PTR = '1;

  typedef enum logic {IDLE, INIT} state_t;

  state_t            state;
  logic [AWIDTH-1:0] ptr;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] init_val;
  logic              wr_ok0;
  logic              wr_ok1;

  assign init_val = (INIT_MODE != 0) ? DWIDTH'(ptr) : '0;
  assign wr_ok0   = r_wr_en0 && !((ZERO_REG != 0) && (r_addr_in0 == '0));
  assign wr_ok1   = r_wr_en1 && !((ZERO_REG != 0) && (r_addr_in1 == '0));

  // control FSM: reset/clear start the sweep, busy and drop flags are registered
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state     <= INIT;
      ptr       <= '0;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          r_wr_drop <= r_wr_en0 | r_wr_en1;
          ptr       <= ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            state  <= IDLE;
            r_busy <= 1'b0;
          end
        end
        default: begin
          r_wr_drop <= 1'b0;
          if (r_clr) begin
            state  <= INIT;
            ptr    <= '0;
            r_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // array update: sweep value in INIT, else port 0 then port 1 so port 1 wins on collision
  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      if (state == INIT) begin
        mem[ptr] <= init_val;
      end else begin
        if (wr_ok0) mem[r_addr_in0] <= r_data_in0;
        if (wr_ok1) mem[r_addr_in1] <= r_data_in1;
      end
    end
  end

  // combinational read lanes, forced to zero while busy or on the hardwired zero entry
  always_comb begin
    r_data_out = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AWIDTH-1:0] ra;
      ra = r_addr_out[k*AWIDTH +: AWIDTH];
      if (r_busy || ((ZERO_REG != 0) && (ra == '0))) begin
        r_data_out[k*DWIDTH +: DWIDTH] = '0;
      end else begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok1 && (r_addr_in1 == ra))
          r_data_out[k*DWIDTH +: DWIDTH] = r_data_in1;
        else if (wr_ok0 && (r_addr_in0 == ra))
          r_data_out[k*DWIDTH +: DWIDTH] = r_data_in0;
        else
          r_data_out[k*DWIDTH +: DWIDTH] = mem[ra];
`else
        r_data_out[k*DWIDTH +: DWIDTH] = mem[ra];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        r_clk;
  logic        r_rst;
  logic        r_clr;
  logic        r_busy;
  logic        r_wr_en0;
  logic [4:0]  r_addr_in0;
  logic [31:0] r_data_in0;
  logic        r_wr_en1;
  logic [4:0]  r_addr_in1;
  logic [31:0] r_data_in1;
  logic        r_wr_drop;
  logic [9:0]  r_addr_out;
  logic [63:0] r_data_out;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_mp dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .r_clr      (r_clr),
    .r_busy     (r_busy),
    .r_wr_en0   (r_wr_en0),
    .r_addr_in0 (r_addr_in0),
    .r_data_in0 (r_data_in0),
    .r_wr_en1   (r_wr_en1),
    .r_addr_in1 (r_addr_in1),
    .r_data_in1 (r_data_in1),
    .r_wr_drop  (r_wr_drop),
    .r_addr_out (r_addr_out),
    .r_data_out (r_data_out)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    r_addr_out = {a1, a0};
    #1;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (r_busy && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    r_rst = 1'b1; r_clr = 1'b0;
    r_wr_en0 = 1'b0; r_addr_in0 = '0; r_data_in0 = '0;
    r_wr_en1 = 1'b0; r_addr_in1 = '0; r_data_in1 = '0;
    r_addr_out = {5'd7, 5'd7};

    // reset sweep
    tick(); tick();
    check("rst_busy", 64'(r_busy), 64'd1);
    check("rst_drop", 64'(r_wr_drop), 64'd0);
    check("rst_data", r_data_out, 64'd0);
    r_rst = 1'b0;
    count_busy(n);
    check("sweep_len", 64'(n), 64'd32);
    rd(5'd7, 5'd0);
    check("init_a7", 64'(r_data_out[31:0]), 64'h7);
    check("init_a0", 64'(r_data_out[63:32]), 64'h0);

    // zero register
    r_wr_en0 = 1'b1; r_addr_in0 = 5'd0; r_data_in0 = 32'hDEADBEEF;
    tick();
    r_wr_en0 = 1'b0;
    rd(5'd1, 5'd0);
    check("zero_rd", 64'(r_data_out[63:32]), 64'h0);
    check("zero_drop", 64'(r_wr_drop), 64'd0);
    check("a1_init", 64'(r_data_out[31:0]), 64'h1);

    // collision on addr 5
    r_wr_en0 = 1'b1; r_addr_in0 = 5'd5; r_data_in0 = 32'hAAAA0000;
    r_wr_en1 = 1'b1; r_addr_in1 = 5'd5; r_data_in1 = 32'h5555FFFF;
    tick();
    r_wr_en0 = 1'b0; r_wr_en1 = 1'b0;
    rd(5'd5, 5'd5);
    check("collide", 64'(r_data_out[31:0]), 64'h5555FFFF);

    // distinct writes on both ports
    r_wr_en0 = 1'b1; r_addr_in0 = 5'd12; r_data_in0 = 32'h11;
    r_wr_en1 = 1'b1; r_addr_in1 = 5'd13; r_data_in1 = 32'h22;
    tick();
    r_wr_en0 = 1'b0; r_wr_en1 = 1'b0;
    rd(5'd12, 5'd13);
    check("dual_w", r_data_out, {32'h22, 32'h11});

    // same-cycle read of a write
    rd(5'd9, 5'd9);
    r_wr_en0 = 1'b1; r_addr_in0 = 5'd9; r_data_in0 = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same", 64'(r_data_out[31:0]), 64'hCAFEF00D);
`else
    check("byp_same", 64'(r_data_out[31:0]), 64'h9);
`endif
    tick();
    r_wr_en0 = 1'b0;
    #1;
    check("byp_next", 64'(r_data_out[31:0]), 64'hCAFEF00D);

    // clear with a simultaneous write, then a write during busy
    r_clr = 1'b1;
    r_wr_en0 = 1'b1; r_addr_in0 = 5'd3; r_data_in0 = 32'h77;
    tick();
    r_clr = 1'b0;
    check("clr_busy", 64'(r_busy), 64'd1);
    check("clr_nodrop", 64'(r_wr_drop), 64'd0);
    r_data_in0 = 32'h1234;
    rd(5'd3, 5'd5);
    check("busy_rd0", r_data_out, 64'd0);
    tick();
    r_wr_en0 = 1'b0;
    check("drop_pulse", 64'(r_wr_drop), 64'd1);
    tick();
    check("drop_end", 64'(r_wr_drop), 64'd0);
    count_busy(n);
    check("clr_len", 64'(n + 2), 64'd32);
    rd(5'd3, 5'd5);
    check("clr_a3", 64'(r_data_out[31:0]), 64'h3);
    check("clr_a5", 64'(r_data_out[63:32]), 64'h5);

    // reset mid-sweep
    r_clr = 1'b1;
    tick();
    r_clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    r_rst = 1'b1;
    tick();
    r_rst = 1'b0;
    check("mid_busy", 64'(r_busy), 64'd1);
    count_busy(n);
    check("mid_len", 64'(n), 64'd32);
    rd(5'd31, 5'd12);
    check("mid_a31", 64'(r_data_out[31:0]), 64'h1F);
    check("mid_a12", 64'(r_data_out[63:32]), 64'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
